decode_issue_queue: RTL and testbench
=====================================

// Module: decode_issue_queue
// PURPOSE
//  Parametrised instruction buffer between fetch and decode. Replaces the single
//  IF/ID register with a DEPTH-entry first-word-fall-through queue of
//  {instruction, pc_plus_four} pairs. Lets fetch keep running while decode is
//  held by the hazard unit. Discards wrong-path entries when decode resolves a
//  taken branch or jump (pc_src).
// PARAMETERS
//  DATA_WIDTH  32  width of instruction and pc_plus_four fields
//  DEPTH       4   number of entries; power of two, >= 2
//  PTR_WIDTH   2   log2(DEPTH); derived, do not override
// PORTS
//  clock            in   1           rising-edge clock
//  reset            in   1           asynchronous, active-high
//  fetch_valid      in   1           fetch offers an instruction this cycle
//  fetch_ready      out  1           queue accepts; push = fetch_valid & fetch_ready
//  instruction_f    in   DATA_WIDTH  fetched instruction
//  pc_plus_four_f   in   DATA_WIDTH  PC+4 of fetched instruction
//  stall_d          in   1           hazard unit holds decode; head is not consumed
//  flush            in   1           taken branch/jump in decode (pc_src)
//  valid_d          out  1           head entry is a real instruction
//  instruction_d    out  DATA_WIDTH  head instruction, NOP when empty
//  pc_plus_four_d   out  DATA_WIDTH  head PC+4, 0 when empty
//  count            out  PTR_WIDTH+1 occupied entries, 0..DEPTH
// BEHAVIOUR
//  State
//   - Entry storage, rd_ptr, wr_ptr (PTR_WIDTH, wrap modulo DEPTH), count.
//   - Asynchronous reset clears pointers and count. Storage is not reset.
//  Reset values
//   - count=0, valid_d=0, instruction_d=NOP (32'h0000_0000), pc_plus_four_d=0.
//   - fetch_ready=1 once reset deasserts; fetch_ready=0 while reset is high.
//  Outputs
//   - valid_d = (count != 0).
//   - When valid_d=1, instruction_d and pc_plus_four_d show the rd_ptr entry
//     (fall-through: combinational from storage).
//   - When valid_d=0, they show NOP and 0 (bubble).
//   - fetch_ready = (count != DEPTH). It has no combinational path from stall_d
//     or flush.
//  Push/pop
//   - pop = valid_d & ~stall_d.
//   - push writes at wr_ptr and increments it. pop increments rd_ptr.
//   - count += push - pop. Push and pop in the same cycle leave count unchanged.
//   - Latency: a pushed entry appears on the outputs the cycle after the push.
//     There is no same-cycle bypass, even when the queue is empty.
//   - When full, fetch_ready=0, so no push that cycle, even if a pop happens.
//  Flush
//   - Takes precedence over push and pop.
//   - Next cycle: count=0, rd_ptr=wr_ptr=0.
//   - Any push in the flush cycle is dropped (wrong path).
//   - The head in the flush cycle is the branch itself. Decode is using it that
//     cycle, and the downstream ID/EX register captures it.
//   - There are no delay slots: every entry behind the head is discarded.
//   - If flush and stall_d are both high, flush still clears the queue. The
//     hazard unit must not raise flush unless the branch operands are resolved.
//  Invariants (assert in sim)
//   - count <= DEPTH.
//   - No push when count==DEPTH.
//   - wr_ptr == rd_ptr + count (mod DEPTH).
// STRUCTURE
//  - NOP_INSTR and DECODE_QUEUE_DEPTH default go in the shared header
//    decode/decode_defs.v (include-guarded). The fetch stage and the hazard unit
//    include it too.
//  - One sub-module: decode_queue_mem, a DEPTH x (2*DATA_WIDTH) register array
//    with one synchronous write port and one asynchronous read port.
//  - Pointer/count logic and output muxing stay in decode_issue_queue.
// TESTING
//  1. Reset mid-traffic: count=3, assert reset -> same cycle count=0, valid_d=0,
//     instruction_d=32'h0. Deassert -> fetch_ready=1.
//  2. Fill: push 0x20080001..0x20080004 with stall_d=1 -> count=4,
//     fetch_ready=0. A 5th offer is not accepted. Head stays 0x20080001.
//  3. Drain: then stall_d=0 -> 0x20080001..4 appear on successive cycles with
//     correct pc_plus_four. valid_d drops after the 4th; output reads NOP.
//  4. Simultaneous: count=2 plus push and pop each cycle for 10 cycles ->
//     count stays 2. Output order matches input order across pointer wrap.
//  5. Flush: count=3, flush=1 with fetch_valid=1 (0xDEADBEEF) -> next cycle
//     count=0, valid_d=0. 0xDEADBEEF never appears on instruction_d.
//  6. Flush with stall: flush=1, stall_d=1, count=4 -> next cycle count=0 and
//     fetch_ready=1.

Source files
------------

// File: rtl/decode_issue_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decode_issue_queue_pkg
//  Purpose  : Shared constants for the fetch/decode boundary. The fetch stage
//             and the hazard unit import the same package.
//  Revision : 1.0 - initial release
// ============================================================================
package decode_issue_queue_pkg;

   // Bubble instruction shown to decode when the queue is empty
   localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;

   // Default geometry of the decode issue queue
   localparam int          DECODE_QUEUE_DEPTH = 4;
   localparam int          DECODE_DATA_WIDTH  = 32;

endpackage : decode_issue_queue_pkg
`default_nettype wire

// File: rtl/decode_queue_mem.sv
`default_nettype none
// ============================================================================
//  Module   : decode_queue_mem
//  Purpose  : DEPTH x WIDTH register array, one synchronous write port and one
//             asynchronous read port. Contents are not reset.
//  Revision : 1.0 - initial release
// ============================================================================
module decode_queue_mem #(
   parameter int WIDTH     = 64,
   parameter int DEPTH     = 4,
   parameter int PTR_WIDTH = 2
) (
   input  logic                 clock,
   input  logic                 wr_en_i,
   input  logic [PTR_WIDTH-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]     wr_data_i,
   input  logic [PTR_WIDTH-1:0] rd_addr_i,
   output logic [WIDTH-1:0]     rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Write the addressed entry on the rising edge; storage holds otherwise
   always_ff @(posedge clock) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Fall-through read: head entry is visible without a clock edge
   assign rd_data_o = mem_q[rd_addr_i];

endmodule : decode_queue_mem
`default_nettype wire

// File: rtl/decode_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : decode_issue_queue
//  Purpose  : First-word-fall-through queue of {instruction, pc_plus_four}
//             between fetch and decode. Absorbs decode stalls and drops all
//             wrong-path entries when decode resolves a taken branch/jump.
//  Revision : 1.0 - initial release
// ============================================================================
module decode_issue_queue
   import decode_issue_queue_pkg::*;
#(
   parameter  int DATA_WIDTH = DECODE_DATA_WIDTH,
   parameter  int DEPTH      = DECODE_QUEUE_DEPTH,
   localparam int PTR_WIDTH  = $clog2(DEPTH)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  fetch_valid,
   output logic                  fetch_ready,
   input  logic [DATA_WIDTH-1:0] instruction_f,
   input  logic [DATA_WIDTH-1:0] pc_plus_four_f,
   input  logic                  stall_d,
   input  logic                  flush,
   output logic                  valid_d,
   output logic [DATA_WIDTH-1:0] instruction_d,
   output logic [DATA_WIDTH-1:0] pc_plus_four_d,
   output logic [PTR_WIDTH:0]    count
);

   localparam logic [PTR_WIDTH:0]   FULL_COUNT = DEPTH[PTR_WIDTH:0];
   localparam logic [PTR_WIDTH:0]   COUNT_ONE  = 1;
   localparam logic [PTR_WIDTH-1:0] PTR_ONE    = 1;

   logic [PTR_WIDTH-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PTR_WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH:0]      count_q, count_d;
   logic                    push;
   logic                    pop;
   logic [2*DATA_WIDTH-1:0] head_entry;

   // fetch_ready depends only on state and reset, never on stall_d or flush;
   // a push offered during a flush is dropped instead.
   assign valid_d     = (count_q != '0);
   assign fetch_ready = ~reset & (count_q != FULL_COUNT);
   assign pop         = valid_d & ~stall_d;
   assign push        = fetch_valid & fetch_ready & ~flush;

   // Next-state for pointers and occupancy; flush wins over push and pop
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // State register with asynchronous clear of pointers and occupancy
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   decode_queue_mem #(
      .WIDTH     (2 * DATA_WIDTH),
      .DEPTH     (DEPTH),
      .PTR_WIDTH (PTR_WIDTH)
   ) u_mem (
      .clock     (clock),
      .wr_en_i   (push),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i ({instruction_f, pc_plus_four_f}),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (head_entry)
   );

   // Empty queue presents a bubble rather than stale storage
   assign instruction_d  = valid_d ? head_entry[2*DATA_WIDTH-1:DATA_WIDTH]
                                   : DATA_WIDTH'(NOP_INSTR);
   assign pc_plus_four_d = valid_d ? head_entry[DATA_WIDTH-1:0] : '0;
   assign count          = count_q;

`ifndef SYNTHESIS
   // Occupancy bound, no overfill, and pointer/count consistency
   always @(posedge clock) begin
      if (!reset) begin
         assert (count_q <= FULL_COUNT);
         assert (!(push && (count_q == FULL_COUNT)));
         assert (wr_ptr_q == PTR_WIDTH'(rd_ptr_q + count_q[PTR_WIDTH-1:0]));
      end
   end
`endif

endmodule : decode_issue_queue
`default_nettype wire

// File: tb/tb_decode_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_issue_queue
//  Purpose  : Directed self-checking bench for decode_issue_queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decode_issue_queue;

   localparam int DW = 32;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          fetch_valid = 1'b0;
   logic          fetch_ready;
   logic [DW-1:0] instruction_f = '0;
   logic [DW-1:0] pc_plus_four_f = '0;
   logic          stall_d = 1'b0;
   logic          flush = 1'b0;
   logic          valid_d;
   logic [DW-1:0] instruction_d;
   logic [DW-1:0] pc_plus_four_d;
   logic [2:0]    count;

   int n_checks = 0;
   int n_errors = 0;

   decode_issue_queue #(
      .DATA_WIDTH (DW),
      .DEPTH      (4)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .fetch_valid    (fetch_valid),
      .fetch_ready    (fetch_ready),
      .instruction_f  (instruction_f),
      .pc_plus_four_f (pc_plus_four_f),
      .stall_d        (stall_d),
      .flush          (flush),
      .valid_d        (valid_d),
      .instruction_d  (instruction_d),
      .pc_plus_four_d (pc_plus_four_d),
      .count          (count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        fv;
      logic [31:0] instr;
      logic [31:0] pc;
      logic        stall;
      logic        e_valid;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
      logic [2:0]  e_count;
      logic        e_ready;
   } vec_t;

   vec_t tbl [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic fv, input logic [31:0] instr, input logic [31:0] pc,
                        input logic stall, input logic fl);
      fetch_valid    = fv;
      instruction_f  = instr;
      pc_plus_four_f = pc;
      stall_d        = stall;
      flush          = fl;
   endtask

   initial begin
      // fill/drain table: outputs are those seen before the edge of that row
      tbl[0] = '{1'b1, 32'h20080001, 32'h104, 1'b1, 1'b0, 32'h0,        32'h0,   3'd0, 1'b1};
      tbl[1] = '{1'b1, 32'h20080002, 32'h108, 1'b1, 1'b1, 32'h20080001, 32'h104, 3'd1, 1'b1};
      tbl[2] = '{1'b1, 32'h20080003, 32'h10c, 1'b1, 1'b1, 32'h20080001, 32'h104, 3'd2, 1'b1};
      tbl[3] = '{1'b1, 32'h20080004, 32'h110, 1'b1, 1'b1, 32'h20080001, 32'h104, 3'd3, 1'b1};
      tbl[4] = '{1'b1, 32'h20080005, 32'h114, 1'b1, 1'b1, 32'h20080001, 32'h104, 3'd4, 1'b0};
      tbl[5] = '{1'b0, 32'h0,        32'h0,   1'b0, 1'b1, 32'h20080001, 32'h104, 3'd4, 1'b0};
      tbl[6] = '{1'b0, 32'h0,        32'h0,   1'b0, 1'b1, 32'h20080002, 32'h108, 3'd3, 1'b1};
      tbl[7] = '{1'b0, 32'h0,        32'h0,   1'b0, 1'b1, 32'h20080003, 32'h10c, 3'd2, 1'b1};
      tbl[8] = '{1'b0, 32'h0,        32'h0,   1'b0, 1'b1, 32'h20080004, 32'h110, 3'd1, 1'b1};
      tbl[9] = '{1'b0, 32'h0,        32'h0,   1'b0, 1'b0, 32'h0,        32'h0,   3'd0, 1'b1};

      // power-on reset
      tick();
      tick();
      check("reset count", 32'(count), 32'd0);
      check("reset valid", 32'(valid_d), 32'd0);
      check("reset instr", instruction_d, 32'h0);
      check("reset pc", pc_plus_four_d, 32'h0);
      check("reset ready low", 32'(fetch_ready), 32'd0);
      #3 reset = 1'b0;
      #1;
      check("post-reset ready", 32'(fetch_ready), 32'd1);
      tick();

      // reset in the middle of traffic
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 32'h1111_0000 + 32'(k), 32'h40 + 32'(4 * k), 1'b1, 1'b0);
         tick();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      #1;
      check("midreset count before", 32'(count), 32'd3);
      #1 reset = 1'b1;
      #1;
      check("midreset count", 32'(count), 32'd0);
      check("midreset valid", 32'(valid_d), 32'd0);
      check("midreset instr", instruction_d, 32'h0);
      check("midreset ready low", 32'(fetch_ready), 32'd0);
      tick();
      #2 reset = 1'b0;
      #1;
      check("midreset ready after", 32'(fetch_ready), 32'd1);
      tick();

      // fill then drain
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].fv, tbl[i].instr, tbl[i].pc, tbl[i].stall, 1'b0);
         #1;
         check($sformatf("vec%0d count", i), 32'(count), 32'(tbl[i].e_count));
         check($sformatf("vec%0d valid", i), 32'(valid_d), 32'(tbl[i].e_valid));
         check($sformatf("vec%0d instr", i), instruction_d, tbl[i].e_instr);
         check($sformatf("vec%0d pc", i), pc_plus_four_d, tbl[i].e_pc);
         check($sformatf("vec%0d ready", i), 32'(fetch_ready), 32'(tbl[i].e_ready));
         @(posedge clock);
         #1;
      end

      // simultaneous push and pop at count=2 across pointer wrap
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 32'h3000_0000 + 32'(k), 32'h2000 + 32'(4 * k), 1'b1, 1'b0);
         tick();
      end
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 32'h3000_0002 + 32'(k), 32'h2008 + 32'(4 * k), 1'b0, 1'b0);
         #1;
         check($sformatf("simul%0d count", k), 32'(count), 32'd2);
         check($sformatf("simul%0d instr", k), instruction_d, 32'h3000_0000 + 32'(k));
         check($sformatf("simul%0d pc", k), pc_plus_four_d, 32'h2000 + 32'(4 * k));
         @(posedge clock);
         #1;
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      check("simul tail0 instr", instruction_d, 32'h3000_000a);
      tick();
      check("simul tail1 instr", instruction_d, 32'h3000_000b);
      check("simul tail1 pc", pc_plus_four_d, 32'h202c);
      tick();
      check("simul empty valid", 32'(valid_d), 32'd0);

      // flush with a wrong-path push in the same cycle
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 32'h5000_0000 + 32'(k), 32'h300 + 32'(4 * k), 1'b1, 1'b0);
         tick();
      end
      drive(1'b1, 32'hDEADBEEF, 32'h999, 1'b0, 1'b1);
      #1;
      check("flush cycle head", instruction_d, 32'h5000_0000);
      check("flush cycle count", 32'(count), 32'd3);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      #1;
      check("post-flush count", 32'(count), 32'd0);
      check("post-flush valid", 32'(valid_d), 32'd0);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("post-flush instr%0d", k), instruction_d, 32'h0);
         tick();
      end
      drive(1'b1, 32'h6000_0001, 32'h404, 1'b1, 1'b0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      #1;
      check("refill count", 32'(count), 32'd1);
      check("refill head", instruction_d, 32'h6000_0001);
      check("refill pc", pc_plus_four_d, 32'h404);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      check("refill drained", 32'(count), 32'd0);

      // flush while stalled and full
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 32'h7000_0000 + 32'(k), 32'h500 + 32'(4 * k), 1'b1, 1'b0);
         tick();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      #1;
      check("full before flush", 32'(count), 32'd4);
      check("full ready low", 32'(fetch_ready), 32'd0);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      check("stall-flush count", 32'(count), 32'd0);
      check("stall-flush ready", 32'(fetch_ready), 32'd1);
      check("stall-flush valid", 32'(valid_d), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_decode_issue_queue
`default_nettype wire
